// File: rtl/mission_seq.sv
// mission_seq: line-follower mission sequencer (IDLE/FOLLOW/TURN/REVERSE/STOP/DONE).
// Define MISSION_TIMEOUT_EN to add a watchdog on FOLLOW/REVERSE that forces STOP with err.
module mission_seq #(
  parameter int unsigned TURN_CYCLES    = 5000000,
  parameter int unsigned SETTLE_CYCLES  = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] target,
  input  logic [2:0] count,
  input  logic       rev_flag,
  output logic       T,
  output logic       REV,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state
);

  localparam int unsigned MAX_A = (TURN_CYCLES > SETTLE_CYCLES) ? TURN_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CW    = (MAX_C < 2) ? 1 : $clog2(MAX_C + 1);

  localparam logic [CW-1:0] TURN_LAST   = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
`ifdef MISSION_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FOLLOW  = 3'd1,
    S_TURN    = 3'd2,
    S_REVERSE = 3'd3,
    S_STOP    = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [2:0]      base_q, base_d;
  logic [2:0]      tgt_q, tgt_d;
  logic            err_q, err_d;
  logic [2:0]      progress;
  logic            counting;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    tgt_d    = tgt_q;
    err_d    = err_q;
    progress = count - base_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          base_d  = count;
          tgt_d   = target;
          err_d   = 1'b0;
          state_d = (target == 3'd0) ? S_TURN : S_FOLLOW;
        end
      end
      S_FOLLOW: begin
        if (abort) begin
          state_d = S_STOP;
          err_d   = 1'b1;
        end
`ifdef MISSION_TIMEOUT_EN
        else if (cyc_q == TIMEOUT_LAST) begin
          state_d = S_STOP;
          err_d   = 1'b1;
        end
`endif
        else if (progress == tgt_q) begin
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        if (abort) begin
          state_d = S_STOP;
          err_d   = 1'b1;
        end else if (cyc_q == TURN_LAST) begin
          state_d = S_REVERSE;
        end
      end
      S_REVERSE: begin
        if (abort) begin
          state_d = S_STOP;
          err_d   = 1'b1;
        end
`ifdef MISSION_TIMEOUT_EN
        else if (cyc_q == TIMEOUT_LAST) begin
          state_d = S_STOP;
          err_d   = 1'b1;
        end
`endif
        else if (rev_flag) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cyc_q == SETTLE_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The counter only runs in timed states and restarts on every state change,
    // so it tops out one below the relevant limit and never wraps.
`ifdef MISSION_TIMEOUT_EN
    counting = (state_q == S_TURN) || (state_q == S_STOP) ||
               (state_q == S_FOLLOW) || (state_q == S_REVERSE);
`else
    counting = (state_q == S_TURN) || (state_q == S_STOP);
`endif
    if (state_d != state_q) begin
      cyc_d = '0;
    end else if (counting) begin
      cyc_d = cyc_q + 1'b1;
    end else begin
      cyc_d = cyc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      base_q  <= '0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      base_q  <= base_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    REV = 1'b1;
    T   = 1'b1;
    case (state_q)
      S_IDLE:    begin REV = 1'b1; T = 1'b1; end
      S_FOLLOW:  begin REV = 1'b0; T = 1'b1; end
      S_TURN:    begin REV = 1'b0; T = 1'b0; end
      S_REVERSE: begin REV = 1'b1; T = 1'b0; end
      default:   begin REV = 1'b1; T = 1'b1; end
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_mission_seq.sv
// Self-checking bench for mission_seq: phase-level reference model plus directed scenarios.
module tb_mission_seq;

  localparam int TURN_C   = 4;
  localparam int SETTLE_C = 3;
  localparam int TMO_C    = 20;
`ifdef MISSION_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] target = '0;
  logic [2:0] count = '0;
  logic       rev_flag = 1'b0;
  logic       T, REV, busy, done, err;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  bit seen_follow = 1'b0;

  mission_seq #(
    .TURN_CYCLES(TURN_C),
    .SETTLE_CYCLES(SETTLE_C),
    .TIMEOUT_CYCLES(TMO_C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .target(target), .count(count), .rev_flag(rev_flag),
    .T(T), .REV(REV), .busy(busy), .done(done), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase number (0..5), cycles already spent in it, latched mission data.
  int         m_st = 0;
  int         m_time = 0;
  int         m_base = 0;
  int         m_tgt = 0;
  bit         m_err = 1'b0;
  int         m_r;
  int         m_nxt;
  int         t_tab[6]   = '{1, 1, 0, 0, 1, 1};
  int         rev_tab[6] = '{1, 0, 0, 1, 1, 1};

  // Returns next_phase*2 + (1 if this step raises the fault flag).
  function automatic int m_step();
    int spent;
    spent = m_time + 1;
    case (m_st)
      0: return (start && !abort) ? ((target == 3'd0) ? 4 : 2) : 0;
      1: begin
        if (abort) return 9;
        if (TMO_ON && spent >= TMO_C) return 9;
        if (((int'(count) - m_base) & 7) == m_tgt) return 4;
        return 2;
      end
      2: begin
        if (abort) return 9;
        return (spent >= TURN_C) ? 6 : 4;
      end
      3: begin
        if (abort) return 9;
        if (TMO_ON && spent >= TMO_C) return 9;
        return rev_flag ? 8 : 6;
      end
      4: return (spent >= SETTLE_C) ? 10 : 8;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; m_time <= 0; m_base <= 0; m_tgt <= 0; m_err <= 1'b0;
    end else begin
      m_r   = m_step();
      m_nxt = m_r >> 1;
      if (m_st == 0 && start && !abort) begin
        m_base <= int'(count);
        m_tgt  <= int'(target);
        m_err  <= 1'b0;
      end else if (m_r[0]) begin
        m_err <= 1'b1;
      end
      m_time <= (m_nxt != m_st) ? 0 : m_time + 1;
      m_st   <= m_nxt;
    end
  end

  always @(negedge clk) begin
    check("state", state, m_st);
    check("T", T, t_tab[m_st]);
    check("REV", REV, rev_tab[m_st]);
    check("busy", busy, (m_st != 0));
    check("done", done, (m_st == 5));
    check("err", err, m_err);
    if (done) done_cnt++;
    if (state == 3'd1) seen_follow = 1'b1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic dwell(input logic [2:0] s, output int n);
    n = 0;
    while (state == s && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    abort = 1'b1; start = 1'b0; rev_flag = 1'b0;
    tick();
    abort = 1'b0;
    while (state != 3'd0 && n < 50) begin
      tick();
      n++;
    end
    check("wait_idle", state, 0);
  endtask

  initial begin
    int n;
    int d0;
    #1_000_000;
    $display("FAIL global_timeout: got 0, want 1 (bench did not finish)");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int d0;
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_revt", {REV, T}, 3);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Nominal mission with counter wrap 6 -> 7 -> 0 -> 1
    count = 3'd6; target = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("nom_follow", state, 1);
    count = 3'd7; tick();
    count = 3'd0; tick();
    count = 3'd1; tick();
    check("nom_turn", state, 2);
    check("nom_model_turn", m_st, 2);
    check("nom_revt", {REV, T}, 0);
    d0 = done_cnt;
    dwell(3'd2, n);
    check("nom_turn_len", n, 4);
    check("nom_reverse", state, 3);
    rev_flag = 1'b1; tick(); rev_flag = 1'b0;
    check("nom_stop", state, 4);
    dwell(3'd4, n);
    check("nom_stop_len", n, 3);
    check("nom_done", done, 1);
    check("nom_model_done", m_st, 5);
    tick();
    check("nom_idle", state, 0);
    check("nom_done_cnt", done_cnt - d0, 1);

    // Zero target skips FOLLOW
    seen_follow = 1'b0;
    target = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_turn", state, 2);
    check("zero_revt", {REV, T}, 0);
    dwell(3'd2, n);
    check("zero_turn_len", n, 4);
    rev_flag = 1'b1; tick(); rev_flag = 1'b0;
    dwell(3'd4, n);
    tick();
    check("zero_idle", state, 0);
    check("zero_no_follow", seen_follow, 0);

    // Abort in the second TURN cycle
    target = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_stop", state, 4);
    check("abort_err", err, 1);
    dwell(3'd4, n);
    check("abort_settle", n, 3);
    check("abort_done", done, 1);
    tick();
    check("abort_err_sticky", err, 1);
    target = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_err_clr", err, 0);
    check("restart_follow", state, 1);
    wait_idle();

    // start+abort in IDLE, then restart while busy
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_idle", state, 0);
    check("sa_busy", busy, 0);
    count = 3'd3; target = 3'd2; start = 1'b1;
    tick();
    check("busy_start_follow", state, 1);
    target = 3'd7;
    tick();
    start = 1'b0;
    count = 3'd4; tick();
    check("busy_start_hold", state, 1);
    count = 3'd5; tick();
    check("busy_start_tgt", state, 2);
    wait_idle();

    // Asynchronous reset during REVERSE
    target = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    dwell(3'd2, n);
    check("rr_reverse", state, 3);
    d0 = done_cnt;
    #3 rst_n = 1'b0;
    #1;
    check("rr_state", state, 0);
    check("rr_revt", {REV, T}, 3);
    check("rr_busy", busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rr_no_done", done_cnt - d0, 0);
    count = 3'd0; target = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("rr_restart", state, 1);

    // Count held constant in FOLLOW
`ifdef MISSION_TIMEOUT_EN
    dwell(3'd1, n);
    check("tmo_len", n, TMO_C);
    check("tmo_stop", state, 4);
    check("tmo_err", err, 1);
`else
    repeat (30) tick();
    check("no_tmo_follow", state, 1);
`endif
    wait_idle();

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      start    = ($urandom % 8 == 0);
      abort    = ($urandom % 40 == 0);
      target   = 3'($urandom);
      rev_flag = ($urandom % 6 == 0);
      if ($urandom % 3 == 0) count = count + 3'd1;
      tick();
    end
    start = 1'b0; abort = 1'b0; rev_flag = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
